hex_entry: RTL and testbench
============================

# hex_entry

Keypad digit-entry stage between the raw push-buttons and the seven-segment display path. Synchronizes and debounces `pb`, turns each accepted press into one edit action (hex digit, backspace, clear) on an 8-digit hex register, and presents the register plus per-digit enables. Downstream, each nibble feeds one seven-segment decoder driving ss0..ss7, so the whole entered number stays visible instead of a single digit.

## Interface
- `DEBOUNCE`, default 3: consecutive identical synchronized samples needed before a press is accepted; legal range 2..15.
- `hz100`  in  1: clock, 100 Hz.
- `reset`  in  1: asynchronous, active-high; all state to reset values immediately.
- `pb`  in  21: raw buttons; [15:0] hex keys 0..F, [16] backspace, [17] clear, [20:18] ignored.
- `digits`  out  32: entered value; nibble i drives display digit i; reset 0.
- `en`  out  8: bit i = 1 iff i < `count`; reset 0.
- `count`  out  4: number of valid digits, 0..8; reset 0.
- `full`  out  1: `count` == 8; reset 0.
- `strobe`  out  1: one-cycle pulse, the cycle after an action is applied; reset 0.

## Operation
- Key encode (combinational, on synchronized pb): priority clear > backspace > highest-index hex key. Code 5 bits: 0..15 hex, 16 BKSP, 17 CLR; `none` when pb[17:0] all zero.
- Two-flop synchronizer on pb[17:0]; reset to 0.
- FSM states IDLE, WAIT, HELD; registers `code` (5 b), `cnt` (4 b); all reset to IDLE/0.
  - IDLE: sample valid -> WAIT, `code`<=sample, `cnt`<=1. Else stay.
  - WAIT: sample none -> IDLE. Sample != `code` -> `code`<=sample, `cnt`<=1 (restart). Sample == `code` and `cnt` == DEBOUNCE-1 -> HELD, action applied this edge, `strobe`<=1. Else `cnt`++.
  - HELD: sample none -> IDLE. Any other sample (incl. different key) -> stay HELD, no action; a new action requires full release first.
- Actions (applied at the accepting edge):
  - hex k, `count` < 8: `digits` <= {digits[27:0], k}, `count`++.
  - hex k, `count` == 8: ignored, no register change; `strobe` still pulses.
  - BKSP, `count` > 0: `digits` <= {4'h0, digits[31:4]}, `count`--. `count` == 0: no change.
  - CLR: `digits` <= 0, `count` <= 0.
- `en`, `full` are pure functions of `count`.

## Timing
- Press held steady from before edge 0: synchronizer output valid after edge 1; FSM enters WAIT at edge 2; action applied at edge DEBOUNCE+1 (edge 4 for default), `digits`/`count` new values visible after that edge; `strobe` high for the following cycle only.
- Glitch shorter than DEBOUNCE samples: no action.
- Key change mid-WAIT restarts debounce for the new code; no action for the old one.
- One action per press regardless of hold duration; no auto-repeat.
- Simultaneous buttons: only the highest-priority code is considered; priority change during WAIT counts as a code change.
- `reset` asserted mid-WAIT or mid-HELD: immediate return to reset values; after release, a still-held button is treated as a fresh press (full latency).

## Structure
- Shared package: code constants (KEY_BKSP = 16, KEY_CLR = 17, KEY_NONE flag), FSM state enum, NDIG = 8.
- One sub-module: `key_encode` (combinational 18-bit -> valid + 5-bit code priority encoder). Synchronizer, FSM, and digit register live in `hex_entry`.

## Test plan
- Reset, press pb[5] for 10 cycles, release -> after edge 4 `digits`=0x00000005, `count`=1, `en`=0x01, exactly one `strobe`.
- Enter 1,2,3,4,5,6,7,8, then 9 -> `digits`=0x12345678, `count`=8, `full`=1; the 9 leaves registers unchanged, `strobe` still pulses.
- From 0x00000123 (count 3) press pb[16] -> 0x00000012, count 2, `en`=0x03; three more backspaces -> 0, count 0, last one no change.
- Hold pb[3] and pb[12] together -> only C entered; with pb[17] also held -> clear wins, `digits`=0.
- 2-cycle pulse on pb[7] (DEBOUNCE=3) -> no action; pb[7] switching to pb[8] mid-WAIT -> only 8 entered, one strobe.
- Assert `reset` while HELD on pb[4] with count 5 -> all outputs 0 immediately; keep pb[4] held through release -> 4 entered DEBOUNCE+1 edges after reset deasserts.

Source files
------------

// File: rtl/hex_entry_pkg.sv
// Shared constants and types for the keypad digit-entry stage.
package hex_entry_pkg;

  localparam int unsigned NDIG = 8;
  localparam int unsigned NKEY = 18;

  localparam logic [4:0] KEY_BKSP = 5'd16;
  localparam logic [4:0] KEY_CLR  = 5'd17;
  // Encoder valid flag value meaning "no button pressed".
  localparam logic       KEY_NONE = 1'b0;

  typedef enum logic [1:0] {StIdle, StWait, StHeld} state_e;

endpackage

// File: rtl/hex_entry_if.sv
// Button inputs and display-side outputs of hex_entry.
interface hex_entry_if;
  import hex_entry_pkg::*;

  logic [20:0]     pb;
  logic [31:0]     digits;
  logic [NDIG-1:0] en;
  logic [3:0]      count;
  logic            full;
  logic            strobe;

  modport master (output pb, input digits, en, count, full, strobe);
  modport slave  (input pb, output digits, en, count, full, strobe);

endinterface

// File: rtl/hex_entry_key_encode.sv
// key_encode: priority encoder, clear > backspace > highest-index hex key.
module hex_entry_key_encode
  import hex_entry_pkg::*;
(
  input  logic [NKEY-1:0] keys_i,
  output logic            valid_o,
  output logic [4:0]      code_o
);

  always_comb begin
    valid_o = |keys_i;
    code_o  = 5'd0;
    for (int i = 0; i < 16; i++) begin
      if (keys_i[i]) code_o = 5'(i);
    end
    if (keys_i[16]) code_o = KEY_BKSP;
    if (keys_i[17]) code_o = KEY_CLR;
  end

endmodule

// File: rtl/hex_entry.sv
// Synchronizes and debounces buttons, applies one edit action per press to an
// 8-digit hex register.
module hex_entry
  import hex_entry_pkg::*;
#(
  parameter int unsigned DEBOUNCE = 3
) (
  input logic       hz100,
  input logic       reset,
  hex_entry_if.slave kp
);

  localparam logic [3:0] LastCnt = 4'(DEBOUNCE - 1);

  logic [NKEY-1:0] sync1_q, sync2_q;
  logic            smp_valid;
  logic [4:0]      smp_code;

  state_e     state_q, state_d;
  logic [4:0] code_q, code_d;
  logic [3:0] cnt_q, cnt_d;
  logic       accept;

  logic [31:0] digits_q;
  logic [3:0]  count_q;
  logic        strobe_q;
  logic        unused_pb;

  assign unused_pb = ^kp.pb[20:18];

  always_ff @(posedge hz100 or posedge reset) begin
    if (reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= kp.pb[NKEY-1:0];
      sync2_q <= sync1_q;
    end
  end

  hex_entry_key_encode u_key_encode (
    .keys_i (sync2_q),
    .valid_o(smp_valid),
    .code_o (smp_code)
  );

  always_ff @(posedge hz100 or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      code_q  <= 5'd0;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      code_q  <= code_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    code_d  = code_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (smp_valid != KEY_NONE) begin
          state_d = StWait;
          code_d  = smp_code;
          cnt_d   = 4'd1;
        end
      end
      StWait: begin
        if (smp_valid == KEY_NONE) begin
          state_d = StIdle;
        end else if (smp_code != code_q) begin
          code_d = smp_code;
          cnt_d  = 4'd1;
        end else if (cnt_q == LastCnt) begin
          state_d = StHeld;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      StHeld: begin
        // Only a full release re-arms; key changes while held are ignored.
        if (smp_valid == KEY_NONE) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    accept = (state_q == StWait) && (smp_valid != KEY_NONE) &&
             (smp_code == code_q) && (cnt_q == LastCnt);
  end

  always_ff @(posedge hz100 or posedge reset) begin
    if (reset) begin
      digits_q <= 32'd0;
      count_q  <= 4'd0;
      strobe_q <= 1'b0;
    end else begin
      strobe_q <= accept;
      if (accept) begin
        if (code_q == KEY_CLR) begin
          digits_q <= 32'd0;
          count_q  <= 4'd0;
        end else if (code_q == KEY_BKSP) begin
          if (count_q != 4'd0) begin
            digits_q <= {4'h0, digits_q[31:4]};
            count_q  <= count_q - 4'd1;
          end
        end else if (count_q < 4'(NDIG)) begin
          digits_q <= {digits_q[27:0], code_q[3:0]};
          count_q  <= count_q + 4'd1;
        end
      end
    end
  end

  always_comb begin
    kp.en = '0;
    for (int i = 0; i < NDIG; i++) begin
      kp.en[i] = (4'(i) < count_q);
    end
  end

  assign kp.digits = digits_q;
  assign kp.count  = count_q;
  assign kp.full   = (count_q == 4'(NDIG));
  assign kp.strobe = strobe_q;

endmodule

// File: tb/tb_hex_entry.sv
// Directed self-checking bench for hex_entry with DEBOUNCE = 3.
module tb_hex_entry;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_bad;
  int   n_strobe;
  int   s0;

  hex_entry_if kp ();

  hex_entry #(.DEBOUNCE(3)) dut (
    .hz100(clk),
    .reset(rst),
    .kp   (kp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial n_strobe = 0;
  always @(negedge clk) if (kp.strobe) n_strobe++;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Advance n active edges and settle 1 time unit past the last one.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic press(input logic [20:0] keys, input int hold);
    kp.pb = keys;
    tick(hold);
    kp.pb = '0;
    tick(6);
  endtask

  task automatic key(input int idx);
    press(21'(1) << idx, 10);
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst   = 1'b1;
    kp.pb = '0;
    tick(2);
    check_eq("rst_digits", kp.digits, 32'h0);
    check_eq("rst_count", 32'(kp.count), 32'd0);
    check_eq("rst_en", 32'(kp.en), 32'h0);
    check_eq("rst_full", 32'(kp.full), 32'd0);
    check_eq("rst_strobe", 32'(kp.strobe), 32'd0);
    rst = 1'b0;
    tick(1);

    // Single press: action at the fifth edge after pb goes high.
    s0 = n_strobe;
    kp.pb = 21'(1) << 5;
    tick(4);
    check_eq("lat_count_before", 32'(kp.count), 32'd0);
    tick(1);
    check_eq("lat_digits", kp.digits, 32'h5);
    check_eq("lat_count", 32'(kp.count), 32'd1);
    check_eq("lat_en", 32'(kp.en), 32'h01);
    check_eq("lat_strobe_hi", 32'(kp.strobe), 32'd1);
    tick(1);
    check_eq("lat_strobe_lo", 32'(kp.strobe), 32'd0);
    tick(4);
    kp.pb = '0;
    tick(6);
    check_eq("lat_one_strobe", 32'(n_strobe - s0), 32'd1);

    // Fill all eight digits, then overflow.
    key(17);
    for (int k = 1; k <= 8; k++) key(k);
    check_eq("full_digits", kp.digits, 32'h12345678);
    check_eq("full_count", 32'(kp.count), 32'd8);
    check_eq("full_flag", 32'(kp.full), 32'd1);
    check_eq("full_en", 32'(kp.en), 32'hFF);
    s0 = n_strobe;
    key(9);
    check_eq("ovf_digits", kp.digits, 32'h12345678);
    check_eq("ovf_count", 32'(kp.count), 32'd8);
    check_eq("ovf_strobe", 32'(n_strobe - s0), 32'd1);

    // Backspace down to empty and once beyond.
    key(17);
    check_eq("clr_full", 32'(kp.full), 32'd0);
    key(1); key(2); key(3);
    check_eq("bs_start", kp.digits, 32'h123);
    s0 = n_strobe;
    key(16);
    check_eq("bs1_digits", kp.digits, 32'h12);
    check_eq("bs1_count", 32'(kp.count), 32'd2);
    check_eq("bs1_en", 32'(kp.en), 32'h03);
    key(16); key(16); key(16);
    check_eq("bs4_digits", kp.digits, 32'h0);
    check_eq("bs4_count", 32'(kp.count), 32'd0);
    check_eq("bs_strobes", 32'(n_strobe - s0), 32'd4);

    // Simultaneous keys: highest hex wins, clear beats everything.
    press((21'(1) << 3) | (21'(1) << 12), 10);
    check_eq("prio_digits", kp.digits, 32'hC);
    check_eq("prio_count", 32'(kp.count), 32'd1);
    press((21'(1) << 3) | (21'(1) << 12) | (21'(1) << 17), 10);
    check_eq("prio_clr_digits", kp.digits, 32'h0);
    check_eq("prio_clr_count", 32'(kp.count), 32'd0);

    // Ignored upper buttons do nothing.
    s0 = n_strobe;
    press(21'h1C0000, 10);
    check_eq("ignored_strobe", 32'(n_strobe - s0), 32'd0);

    // Short glitch, then a key change during debounce.
    s0 = n_strobe;
    press(21'(1) << 7, 2);
    check_eq("glitch_count", 32'(kp.count), 32'd0);
    check_eq("glitch_strobe", 32'(n_strobe - s0), 32'd0);
    kp.pb = 21'(1) << 7;
    tick(1);
    press(21'(1) << 8, 10);
    check_eq("switch_digits", kp.digits, 32'h8);
    check_eq("switch_count", 32'(kp.count), 32'd1);
    check_eq("switch_strobe", 32'(n_strobe - s0), 32'd1);

    // Asynchronous reset while held, then fresh press after release.
    key(17);
    key(1); key(2); key(3); key(4);
    kp.pb = 21'(1) << 4;
    tick(8);
    check_eq("held_count", 32'(kp.count), 32'd5);
    check_eq("held_digits", kp.digits, 32'h12344);
    #2;
    rst = 1'b1;
    #1;
    check_eq("arst_digits", kp.digits, 32'h0);
    check_eq("arst_count", 32'(kp.count), 32'd0);
    check_eq("arst_en", 32'(kp.en), 32'h0);
    tick(3);
    rst = 1'b0;
    tick(4);
    check_eq("post_rst_before", 32'(kp.count), 32'd0);
    tick(1);
    check_eq("post_rst_digits", kp.digits, 32'h4);
    check_eq("post_rst_count", 32'(kp.count), 32'd1);
    kp.pb = '0;
    tick(6);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
